// File: rtl/acc_arbiter.sv
// acc_arbiter: round-robin arbiter sharing one accelerator between NumReq
// offloading requesters. Request (Q) channels are multiplexed onto one master
// port with the requester index prepended to the ID. Responses (P) are routed
// back by decoding that index tag.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   slv_q_*                per-requester request channels (payload, valid/ready)
//   slv_p_*                per-requester response channels (payload broadcast)
//   mst_q_*                shared accelerator request port, id = {idx, slv id}
//   mst_p_*                shared accelerator response port
//   drop_o                 pulses when a response with an out-of-range tag is discarded
//
// Optional build macro:
//   ACC_ARBITER_P_REG_EN   adds a one-entry response register after the index decode
module acc_arbiter #(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = 5,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned IdxWidth   = (NumReq > 1) ? $clog2(NumReq) : 1,
    parameter int unsigned MstIdWidth = IdWidth + IdxWidth
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]      slv_q_addr_i,
    input  logic [NumReq-1:0][31:0]               slv_q_data_op_i,
    input  logic [NumReq-1:0][2:0][DataWidth-1:0] slv_q_data_args_i,
    input  logic [NumReq-1:0][IdWidth-1:0]        slv_q_id_i,
    input  logic [NumReq-1:0]                     slv_q_valid_i,
    output logic [NumReq-1:0]                     slv_q_ready_o,
    output logic [NumReq-1:0][DataWidth-1:0]      slv_p_data_o,
    output logic [NumReq-1:0][IdWidth-1:0]        slv_p_id_o,
    output logic [NumReq-1:0]                     slv_p_error_o,
    output logic [NumReq-1:0]                     slv_p_valid_o,
    input  logic [NumReq-1:0]                     slv_p_ready_i,
    output logic [AddrWidth-1:0]                  mst_q_addr_o,
    output logic [31:0]                           mst_q_data_op_o,
    output logic [2:0][DataWidth-1:0]             mst_q_data_args_o,
    output logic [MstIdWidth-1:0]                 mst_q_id_o,
    output logic                                  mst_q_valid_o,
    input  logic                                  mst_q_ready_i,
    input  logic [DataWidth-1:0]                  mst_p_data_i,
    input  logic [MstIdWidth-1:0]                 mst_p_id_i,
    input  logic                                  mst_p_error_i,
    input  logic                                  mst_p_valid_i,
    output logic                                  mst_p_ready_o,
    output logic                                  drop_o
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 1);

    logic [IdxWidth-1:0] rr_q;
    logic [IdxWidth-1:0] lidx_q;
    logic                lock_q;
    logic [IdxWidth-1:0] arb_gnt;
    logic [IdxWidth-1:0] gnt;

    // Cyclic search from rr_q: the second pass overrides the first whenever a
    // valid requester exists at or above the pointer; descending loops leave the
    // lowest matching index as the winner.
    always_comb begin
        arb_gnt = '0;
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            if (slv_q_valid_i[i]) arb_gnt = IdxWidth'(i);
        end
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            if (slv_q_valid_i[i] && (IdxWidth'(i) >= rr_q)) arb_gnt = IdxWidth'(i);
        end
    end

    assign gnt = lock_q ? lidx_q : arb_gnt;

    // Q path: payload mux and ready steering, all forced low during reset.
    always_comb begin
        mst_q_valid_o     = 1'b0;
        mst_q_addr_o      = '0;
        mst_q_data_op_o   = '0;
        mst_q_data_args_o = '0;
        mst_q_id_o        = '0;
        slv_q_ready_o     = '0;
        if (!rst_i) begin
            // A locked request only stays valid while its owner keeps valid high.
            mst_q_valid_o      = lock_q ? slv_q_valid_i[lidx_q] : |slv_q_valid_i;
            mst_q_addr_o       = slv_q_addr_i[gnt];
            mst_q_data_op_o    = slv_q_data_op_i[gnt];
            mst_q_data_args_o  = slv_q_data_args_i[gnt];
            mst_q_id_o         = {gnt, slv_q_id_i[gnt]};
            slv_q_ready_o[gnt] = mst_q_ready_i;
        end
    end

    // Round-robin pointer and grant lock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
        end else if (mst_q_valid_o) begin
            if (mst_q_ready_i) begin
                lock_q <= 1'b0;
                rr_q   <= (gnt == LastIdx) ? '0 : gnt + IdxWidth'(1);
            end else begin
                lock_q <= 1'b1;
                lidx_q <= gnt;
            end
        end else begin
            // Idle, or the locked requester withdrew: release without a handshake.
            lock_q <= 1'b0;
        end
    end

    // P path: index decode.
    logic [IdxWidth-1:0] p_idx;
    logic                p_in_range;
    logic [IdxWidth-1:0] sel_idx;
    logic                sel_ready;

    assign p_idx      = mst_p_id_i[MstIdWidth-1 -: IdxWidth];
    assign p_in_range = {1'b0, p_idx} < (IdxWidth + 1)'(NumReq);

    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (sel_idx == IdxWidth'(i)) sel_ready = slv_p_ready_i[i];
        end
    end

`ifdef ACC_ARBITER_P_REG_EN
    logic                 full_q;
    logic [IdxWidth-1:0]  idx_q;
    logic [DataWidth-1:0] data_q;
    logic [IdWidth-1:0]   id_q;
    logic                 err_q;
    logic                 enq;

    assign sel_idx = idx_q;
    assign enq     = mst_p_valid_i && p_in_range && mst_p_ready_o;

    // One-entry response buffer; payload only loads on enqueue so it holds under stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
        end else if (enq) begin
            full_q <= 1'b1;
            idx_q  <= p_idx;
            data_q <= mst_p_data_i;
            id_q   <= mst_p_id_i[IdWidth-1:0];
            err_q  <= mst_p_error_i;
        end else if (full_q && sel_ready) begin
            full_q <= 1'b0;
        end
    end

    always_comb begin
        mst_p_ready_o = 1'b0;
        drop_o        = 1'b0;
        slv_p_valid_o = '0;
        slv_p_data_o  = '0;
        slv_p_id_o    = '0;
        slv_p_error_o = '0;
        if (!rst_i) begin
            drop_o        = mst_p_valid_i && !p_in_range;
            mst_p_ready_o = p_in_range ? (!full_q || sel_ready) : 1'b1;
            for (int i = 0; i < int'(NumReq); i++) begin
                slv_p_valid_o[i] = full_q && (idx_q == IdxWidth'(i));
                slv_p_data_o[i]  = data_q;
                slv_p_id_o[i]    = id_q;
                slv_p_error_o[i] = err_q;
            end
        end
    end
`else
    assign sel_idx = p_idx;

    always_comb begin
        mst_p_ready_o = 1'b0;
        drop_o        = 1'b0;
        slv_p_valid_o = '0;
        slv_p_data_o  = '0;
        slv_p_id_o    = '0;
        slv_p_error_o = '0;
        if (!rst_i) begin
            drop_o        = mst_p_valid_i && !p_in_range;
            mst_p_ready_o = p_in_range ? sel_ready : 1'b1;
            for (int i = 0; i < int'(NumReq); i++) begin
                slv_p_valid_o[i] = mst_p_valid_i && p_in_range && (p_idx == IdxWidth'(i));
                slv_p_data_o[i]  = mst_p_data_i;
                slv_p_id_o[i]    = mst_p_id_i[IdWidth-1:0];
                slv_p_error_o[i] = mst_p_error_i;
            end
        end
    end
`endif

endmodule

// File: tb/tb_acc_arbiter.sv
// Directed testbench for acc_arbiter: a 4-requester instance exercises
// arbitration, locking, reset and response routing; a 3-requester instance
// exercises out-of-range response tags. Expected P-path latency follows
// ACC_ARBITER_P_REG_EN.
module tb_acc_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned IW = 4;
    localparam int unsigned MW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-requester instance
    logic [3:0][AW-1:0]      q_addr;
    logic [3:0][31:0]        q_op;
    logic [3:0][2:0][DW-1:0] q_args;
    logic [3:0][IW-1:0]      q_id;
    logic [3:0]              q_valid, q_ready;
    logic [3:0][DW-1:0]      p_data;
    logic [3:0][IW-1:0]      p_id;
    logic [3:0]              p_err, p_valid, p_ready;
    logic [AW-1:0]           m_addr;
    logic [31:0]             m_op;
    logic [2:0][DW-1:0]      m_args;
    logic [MW-1:0]           m_qid;
    logic                    m_qvalid, m_qready;
    logic [DW-1:0]           m_pdata;
    logic [MW-1:0]           m_pid;
    logic                    m_perr, m_pvalid, m_pready, drop;

    // 3-requester instance
    logic [2:0][AW-1:0]      c_q_addr;
    logic [2:0][31:0]        c_q_op;
    logic [2:0][2:0][DW-1:0] c_q_args;
    logic [2:0][IW-1:0]      c_q_id;
    logic [2:0]              c_q_valid, c_q_ready;
    logic [2:0][DW-1:0]      c_p_data;
    logic [2:0][IW-1:0]      c_p_id;
    logic [2:0]              c_p_err, c_p_valid, c_p_ready;
    logic [AW-1:0]           c_m_addr;
    logic [31:0]             c_m_op;
    logic [2:0][DW-1:0]      c_m_args;
    logic [MW-1:0]           c_m_qid;
    logic                    c_m_qvalid, c_m_qready;
    logic [DW-1:0]           c_m_pdata;
    logic [MW-1:0]           c_m_pid;
    logic                    c_m_perr, c_m_pvalid, c_m_pready, c_drop;

    acc_arbiter #(.NumReq(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .slv_q_addr_i(q_addr), .slv_q_data_op_i(q_op), .slv_q_data_args_i(q_args),
        .slv_q_id_i(q_id), .slv_q_valid_i(q_valid), .slv_q_ready_o(q_ready),
        .slv_p_data_o(p_data), .slv_p_id_o(p_id), .slv_p_error_o(p_err),
        .slv_p_valid_o(p_valid), .slv_p_ready_i(p_ready),
        .mst_q_addr_o(m_addr), .mst_q_data_op_o(m_op), .mst_q_data_args_o(m_args),
        .mst_q_id_o(m_qid), .mst_q_valid_o(m_qvalid), .mst_q_ready_i(m_qready),
        .mst_p_data_i(m_pdata), .mst_p_id_i(m_pid), .mst_p_error_i(m_perr),
        .mst_p_valid_i(m_pvalid), .mst_p_ready_o(m_pready), .drop_o(drop)
    );

    acc_arbiter #(.NumReq(3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .slv_q_addr_i(c_q_addr), .slv_q_data_op_i(c_q_op), .slv_q_data_args_i(c_q_args),
        .slv_q_id_i(c_q_id), .slv_q_valid_i(c_q_valid), .slv_q_ready_o(c_q_ready),
        .slv_p_data_o(c_p_data), .slv_p_id_o(c_p_id), .slv_p_error_o(c_p_err),
        .slv_p_valid_o(c_p_valid), .slv_p_ready_i(c_p_ready),
        .mst_q_addr_o(c_m_addr), .mst_q_data_op_o(c_m_op), .mst_q_data_args_o(c_m_args),
        .mst_q_id_o(c_m_qid), .mst_q_valid_o(c_m_qvalid), .mst_q_ready_i(c_m_qready),
        .mst_p_data_i(c_m_pdata), .mst_p_id_i(c_m_pid), .mst_p_error_i(c_m_perr),
        .mst_p_valid_i(c_m_pvalid), .mst_p_ready_o(c_m_pready), .drop_o(c_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; q_valid = 4'hF; m_qready = 1'b1;
        m_pvalid = 1'b1; m_pid = {2'd1, 4'h2}; p_ready = 4'hF;
        c_m_pvalid = 1'b1; c_m_pid = {2'd3, 4'h0};
        @(negedge clk);
        checks++; if (m_qvalid !== 1'b0) begin errors++; $display("FAIL reset_mst_q_valid: got %b expected 0", m_qvalid); end
        checks++; if (q_ready !== 4'h0) begin errors++; $display("FAIL reset_slv_q_ready: got %b expected 0000", q_ready); end
        checks++; if (p_valid !== 4'h0) begin errors++; $display("FAIL reset_slv_p_valid: got %b expected 0000", p_valid); end
        checks++; if (m_pready !== 1'b0) begin errors++; $display("FAIL reset_mst_p_ready: got %b expected 0", m_pready); end
        checks++; if (c_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", c_drop); end
        checks++; if (c_m_pready !== 1'b0) begin errors++; $display("FAIL reset_mst_p_ready3: got %b expected 0", c_m_pready); end
        tick();
        rst = 1'b0; q_valid = 4'h0; m_pvalid = 1'b0; c_m_pvalid = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        q_valid = 4'hF; m_qready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (m_qid[5:4] !== 2'(exp_g[k])) begin errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, m_qid[5:4], exp_g[k]); end
            checks++; if (m_qid[3:0] !== 4'(exp_g[k] + 4)) begin errors++; $display("FAIL rr_id[%0d]: got %h expected %h", k, m_qid[3:0], exp_g[k] + 4); end
            checks++; if (m_addr !== AW'(exp_g[k] + 1)) begin errors++; $display("FAIL rr_addr[%0d]: got %0d expected %0d", k, m_addr, exp_g[k] + 1); end
            checks++; if (m_args[1] !== DW'(exp_g[k] * 16 + 1)) begin errors++; $display("FAIL rr_arg_b[%0d]: got %h expected %h", k, m_args[1], exp_g[k] * 16 + 1); end
            checks++; if (q_ready !== 4'(1 << exp_g[k])) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, q_ready, 4'(1 << exp_g[k])); end
            checks++; if (m_qvalid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", k, m_qvalid); end
            tick();
        end
    endtask

    task automatic test_lock();
        // Single handshake on req2 moves the pointer to 3.
        q_valid = 4'b0100; m_qready = 1'b1;
        @(negedge clk);
        checks++; if (m_qid[5:4] !== 2'd2) begin errors++; $display("FAIL lock_pre_grant: got %0d expected 2", m_qid[5:4]); end
        tick();
        q_valid = 4'b0010; m_qready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (m_qid[5:4] !== 2'd1) begin errors++; $display("FAIL lock_grant[%0d]: got %0d expected 1", k, m_qid[5:4]); end
            checks++; if (m_op !== 32'hA000_0001) begin errors++; $display("FAIL lock_op[%0d]: got %h expected a0000001", k, m_op); end
            checks++; if (q_ready !== 4'b0000) begin errors++; $display("FAIL lock_ready[%0d]: got %b expected 0000", k, q_ready); end
            tick();
            q_valid = 4'b0111;
        end
        m_qready = 1'b1;
        @(negedge clk);
        checks++; if (q_ready !== 4'b0010) begin errors++; $display("FAIL lock_release_ready: got %b expected 0010", q_ready); end
        tick();
        @(negedge clk);
        checks++; if (m_qid[5:4] !== 2'd2) begin errors++; $display("FAIL lock_next_grant: got %0d expected 2", m_qid[5:4]); end
        tick();
    endtask

    task automatic test_violation();
        // Pointer is 3. Lock on req3, req3 withdraws, pointer must stay at 3.
        q_valid = 4'b1000; m_qready = 1'b0;
        @(negedge clk);
        checks++; if (m_qid[5:4] !== 2'd3) begin errors++; $display("FAIL viol_grant: got %0d expected 3", m_qid[5:4]); end
        tick();
        q_valid = 4'b0001;
        tick();
        q_valid = 4'b1001; m_qready = 1'b1;
        @(negedge clk);
        checks++; if (m_qid[5:4] !== 2'd3) begin errors++; $display("FAIL viol_after_grant: got %0d expected 3", m_qid[5:4]); end
        tick();
    endtask

    task automatic test_reset_mid_lock();
        q_valid = 4'b0100; m_qready = 1'b0;
        @(negedge clk);
        checks++; if (m_qid[5:4] !== 2'd2) begin errors++; $display("FAIL rml_grant: got %0d expected 2", m_qid[5:4]); end
        tick();
        rst = 1'b1; q_valid = 4'hF; m_qready = 1'b1;
        m_pvalid = 1'b1; m_pid = {2'd1, 4'h3}; p_ready = 4'hF;
        c_m_pvalid = 1'b1; c_m_pid = {2'd3, 4'h1};
        @(negedge clk);
        checks++; if (m_qvalid !== 1'b0) begin errors++; $display("FAIL rml_mst_q_valid: got %b expected 0", m_qvalid); end
        checks++; if (q_ready !== 4'h0) begin errors++; $display("FAIL rml_slv_q_ready: got %b expected 0000", q_ready); end
        checks++; if (p_valid !== 4'h0) begin errors++; $display("FAIL rml_slv_p_valid: got %b expected 0000", p_valid); end
        checks++; if (m_pready !== 1'b0) begin errors++; $display("FAIL rml_mst_p_ready: got %b expected 0", m_pready); end
        checks++; if (c_drop !== 1'b0) begin errors++; $display("FAIL rml_drop: got %b expected 0", c_drop); end
        tick();
        rst = 1'b0; m_pvalid = 1'b0; c_m_pvalid = 1'b0;
        @(negedge clk);
        checks++; if (m_qid[5:4] !== 2'd0) begin errors++; $display("FAIL rml_first_grant: got %0d expected 0", m_qid[5:4]); end
        tick();
        q_valid = 4'h0;
    endtask

    task automatic test_response_routing();
        m_pdata = 32'hDEAD_BEEF; m_perr = 1'b1; m_pid = {2'd3, 4'hA};
        m_pvalid = 1'b1; p_ready = 4'b0111;
`ifdef ACC_ARBITER_P_REG_EN
        @(negedge clk);
        checks++; if (m_pready !== 1'b1) begin errors++; $display("FAIL route_accept: got %b expected 1", m_pready); end
        checks++; if (p_valid !== 4'b0000) begin errors++; $display("FAIL route_latency: got %b expected 0000", p_valid); end
        tick();
        m_pvalid = 1'b0;
`endif
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (p_valid !== 4'b1000) begin errors++; $display("FAIL route_valid[%0d]: got %b expected 1000", k, p_valid); end
            checks++; if (p_id[3] !== 4'hA) begin errors++; $display("FAIL route_id[%0d]: got %h expected a", k, p_id[3]); end
            checks++; if (p_data[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL route_data_bcast[%0d]: got %h expected deadbeef", k, p_data[0]); end
            checks++; if (p_err !== 4'hF) begin errors++; $display("FAIL route_err_bcast[%0d]: got %b expected 1111", k, p_err); end
            checks++; if (m_pready !== 1'b0) begin errors++; $display("FAIL route_stall_ready[%0d]: got %b expected 0", k, m_pready); end
            tick();
        end
        p_ready = 4'hF;
        @(negedge clk);
        checks++; if (p_valid !== 4'b1000) begin errors++; $display("FAIL route_valid_final: got %b expected 1000", p_valid); end
        checks++; if (m_pready !== 1'b1) begin errors++; $display("FAIL route_ready_final: got %b expected 1", m_pready); end
        tick();
        m_pvalid = 1'b0; m_perr = 1'b0;
        @(negedge clk);
        checks++; if (p_valid !== 4'b0000) begin errors++; $display("FAIL route_idle: got %b expected 0000", p_valid); end
        tick();
    endtask

    task automatic test_out_of_range();
        c_m_pid = {2'd3, 4'h5}; c_m_pdata = 32'h1234; c_m_pvalid = 1'b1; c_p_ready = 3'b000;
        @(negedge clk);
        checks++; if (c_m_pready !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b expected 1", c_m_pready); end
        checks++; if (c_drop !== 1'b1) begin errors++; $display("FAIL oor_drop: got %b expected 1", c_drop); end
        checks++; if (c_p_valid !== 3'b000) begin errors++; $display("FAIL oor_valid: got %b expected 000", c_p_valid); end
        tick();
        c_m_pvalid = 1'b0;
        @(negedge clk);
        checks++; if (c_drop !== 1'b0) begin errors++; $display("FAIL oor_drop_once: got %b expected 0", c_drop); end
        checks++; if (c_p_valid !== 3'b000) begin errors++; $display("FAIL oor_valid_after: got %b expected 000", c_p_valid); end
        tick();
        c_m_pid = {2'd2, 4'h1}; c_m_pvalid = 1'b1; c_p_ready = 3'b100;
        @(negedge clk);
        checks++; if (c_drop !== 1'b0) begin errors++; $display("FAIL inr_drop: got %b expected 0", c_drop); end
        checks++; if (c_m_pready !== 1'b1) begin errors++; $display("FAIL inr_ready: got %b expected 1", c_m_pready); end
`ifdef ACC_ARBITER_P_REG_EN
        tick();
        c_m_pvalid = 1'b0;
        @(negedge clk);
`endif
        checks++; if (c_p_valid !== 3'b100) begin errors++; $display("FAIL inr_valid: got %b expected 100", c_p_valid); end
        checks++; if (c_p_id[2] !== 4'h1) begin errors++; $display("FAIL inr_id: got %h expected 1", c_p_id[2]); end
        tick();
        c_m_pvalid = 1'b0;
        @(negedge clk);
        checks++; if (c_p_valid !== 3'b000) begin errors++; $display("FAIL inr_idle: got %b expected 000", c_p_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        p_ready = 4'hF;
`ifdef ACC_ARBITER_P_REG_EN
        for (int k = 0; k < 4; k++) begin
            m_pvalid = (k < 3);
            m_pid = {2'(k), 4'(k + 1)}; m_pdata = DW'(100 + k);
            @(negedge clk);
            if (k < 3) begin
                checks++; if (m_pready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, m_pready); end
            end
            if (k == 0) begin
                checks++; if (p_valid !== 4'b0000) begin errors++; $display("FAIL b2b_latency: got %b expected 0000", p_valid); end
            end else begin
                checks++; if (p_valid !== 4'(1 << (k - 1))) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", k, p_valid, 4'(1 << (k - 1))); end
                checks++; if (p_data[0] !== DW'(100 + k - 1)) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", k, p_data[0], 100 + k - 1); end
                checks++; if (p_id[k-1] !== 4'(k)) begin errors++; $display("FAIL b2b_id[%0d]: got %0d expected %0d", k, p_id[k-1], k); end
            end
            tick();
        end
        @(negedge clk);
        checks++; if (p_valid !== 4'b0000) begin errors++; $display("FAIL b2b_drain: got %b expected 0000", p_valid); end
        tick();
        // Stall: entry for req1 held while a second response waits.
        m_pid = {2'd1, 4'h7}; m_pdata = 32'd55; m_pvalid = 1'b1;
        tick();
        m_pid = {2'd2, 4'h8}; m_pdata = 32'd66; p_ready = 4'b1101;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (p_valid !== 4'b0010) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 0010", k, p_valid); end
            checks++; if (p_data[1] !== 32'd55) begin errors++; $display("FAIL stall_data[%0d]: got %0d expected 55", k, p_data[1]); end
            checks++; if (m_pready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 0", k, m_pready); end
            tick();
        end
        p_ready = 4'hF;
        @(negedge clk);
        checks++; if (m_pready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", m_pready); end
        tick();
        m_pvalid = 1'b0;
        @(negedge clk);
        checks++; if (p_valid !== 4'b0100) begin errors++; $display("FAIL stall_next_valid: got %b expected 0100", p_valid); end
        checks++; if (p_data[2] !== 32'd66) begin errors++; $display("FAIL stall_next_data: got %0d expected 66", p_data[2]); end
        tick();
`else
        for (int k = 0; k < 3; k++) begin
            m_pvalid = 1'b1; m_pid = {2'(k), 4'(k + 1)}; m_pdata = DW'(100 + k);
            @(negedge clk);
            checks++; if (m_pready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, m_pready); end
            checks++; if (p_valid !== 4'(1 << k)) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", k, p_valid, 4'(1 << k)); end
            checks++; if (p_data[3] !== DW'(100 + k)) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", k, p_data[3], 100 + k); end
            checks++; if (p_id[k] !== 4'(k + 1)) begin errors++; $display("FAIL b2b_id[%0d]: got %0d expected %0d", k, p_id[k], k + 1); end
            tick();
        end
        m_pvalid = 1'b0;
`endif
    endtask

    initial begin
        rst = 1'b1;
        q_valid = '0; m_qready = 1'b0; p_ready = '0;
        m_pdata = '0; m_pid = '0; m_perr = 1'b0; m_pvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q_addr[i] = AW'(i + 1);
            q_op[i]   = 32'hA000_0000 | 32'(i);
            q_id[i]   = IW'(i + 4);
            for (int j = 0; j < 3; j++) q_args[i][j] = DW'(i * 16 + j);
        end
        c_q_addr = '0; c_q_op = '0; c_q_args = '0; c_q_id = '0; c_q_valid = '0;
        c_m_qready = 1'b0; c_p_ready = '0;
        c_m_pdata = '0; c_m_pid = '0; c_m_perr = 1'b0; c_m_pvalid = 1'b0;
        tick();
        test_reset();
        test_round_robin();
        test_lock();
        test_violation();
        test_reset_mid_lock();
        test_response_routing();
        test_out_of_range();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
